sync_fifo_wr_arbiter: RTL and testbench
=======================================

Name: sync_fifo_wr_arbiter

Overview:
Round-robin write arbiter that lets N_REQ producers share the write port of one sync_FIFO_buffer instance.
- Grants one requester at a time and holds the grant for a bounded burst.
- Forwards the granted requester's valid/data to the FIFO write side and back-pressures on fifo_full_i.
- Sits directly in front of the FIFO; read side is untouched.

Parameters:
DATA_WIDTH, 32, width of each data word; matches the FIFO DATA_WIDTH
N_REQ, 4, number of requesters; must be >= 2
MAX_BURST, 4, maximum writes per grant; must be >= 1
ID_W, $clog2(N_REQ), width of grant index (derived localparam)

Ports:
clk_i  input  1  system clock, rising edge
rst_n_i  input  1  asynchronous active-low reset
req_valid_i  input  N_REQ  per-requester write request
req_data_i  input  N_REQ*DATA_WIDTH  packed data; requester k at bits [k*DATA_WIDTH +: DATA_WIDTH]
req_ready_o  output  N_REQ  per-requester accept; a transfer occurs when valid & ready are both high
fifo_full_i  input  1  FIFO full flag
fifo_write_o  output  1  FIFO write strobe
fifo_wr_data_o  output  DATA_WIDTH  FIFO write data
grant_o  output  N_REQ  one-hot current grant; all zero when IDLE
grant_id_o  output  ID_W  index of the current grant; 0 when IDLE
burst_cnt_o  output  $clog2(MAX_BURST+1)  writes completed in the current grant

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE.
  - rr_ptr = 0.
  - grant_o = 0, grant_id_o = 0, burst_cnt_o = 0.
  - fifo_write_o = 0, req_ready_o = 0. fifo_wr_data_o = 0 while not granted.
- FSM states: IDLE, BURST.
- IDLE:
  - If any req_valid_i is high, select the first valid index searching upward from rr_ptr, wrapping at N_REQ.
  - Register the grant. Go to BURST with burst_cnt = 0.
  - No write occurs in IDLE. Arbitration latency is 1 cycle from valid to first possible write.
- BURST, granted index g (combinational forward):
  - req_ready_o[g] = !fifo_full_i. All other ready bits are 0.
  - fifo_write_o = req_valid_i[g] & !fifo_full_i.
  - fifo_wr_data_o = req_data_i[g].
- BURST, each transfer: burst_cnt increments.
- BURST release: release the grant at the clock edge where either
  - a transfer makes burst_cnt reach MAX_BURST, or
  - req_valid_i[g] is low.
  On release: rr_ptr = (g+1) mod N_REQ, state = IDLE, grant cleared. Minimum 1 idle cycle between grants.
- FIFO full during BURST:
  - No write; burst_cnt holds; grant holds indefinitely.
  - This is not a release condition as long as valid stays high.
- Valid dropping while full: the grant is released; burst_cnt is discarded.
- Non-granted requesters must hold valid/data stable until accepted; the arbiter never drops a pending request.
- Fairness: each requester that continuously asserts valid is granted within N_REQ-1 intervening grants.
- Counter width must represent MAX_BURST exactly; no wrap inside a grant.
- Reset mid-burst: immediate return to the reset state; the partially completed burst is not resumed.
- No X propagation: fifo_wr_data_o is 0 when grant_o == 0.

Decomposition:
- Package sync_fifo_arb_pkg holds:
  - the FSM state enum (IDLE, BURST);
  - a function computing the round-robin next index from a valid vector and a pointer.
- One sub-module: rr_priority_picker, combinational. Inputs: valid vector and rr_ptr. Outputs: found flag, one-hot, index. Reusable by a read-side scheduler.
- The top keeps the FSM, the counter, rr_ptr and the muxing.

Test Plan:
1. Single requester: N_REQ=4, MAX_BURST=4, req 2 valid with data 0xA0..0xA5, FIFO never full.
   -> grant_id_o=2 one cycle after valid; writes 0xA0..0xA3 on 4 consecutive cycles; 1 idle cycle; regrant to 2; writes 0xA4, 0xA5; release when valid drops.
2. All four requesters continuously valid, rr_ptr=0.
   -> grant order 0,1,2,3,0; each grant gives exactly 4 writes; 5 cycles per grant.
3. FIFO full asserted for 3 cycles mid-burst after 2 writes from req 1.
   -> fifo_write_o=0 and req_ready_o[1]=0 for those 3 cycles; burst_cnt_o stays 2; then 2 more writes; then release.
4. Requester 3 drops valid after 1 write while reqs 0 and 3 are pending.
   -> release after the 1 write; rr_ptr=0; next grant goes to 0.
5. rst_n_i asserted asynchronously mid-burst (burst_cnt=2).
   -> all outputs 0 immediately, before the next clock edge; after release, the first grant goes to the lowest valid index.
6. Scoreboard with MAX_BURST=1 and random valids.
   -> FIFO contents equal the per-requester order of accepted words; no requester waits more than N_REQ-1 grants.

Source files
------------

// File: rtl/sync_fifo_arb_pkg.sv
// rtl/sync_fifo_arb_pkg.sv - shared state type and round-robin search helper for the FIFO write arbiter
package sync_fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int RR_MAX_N = 64;

    // First set index at or above ptr, wrapping at n; -1 when nothing is set.
    // Walks downward so the lowest offset from ptr is the last assignment.
    function automatic int rr_next_index(input logic [RR_MAX_N-1:0] valid,
                                         input int ptr,
                                         input int n);
        int idx;
        rr_next_index = -1;
        for (int i = n - 1; i >= 0; i--) begin
            idx = (ptr + i) % n;
            if (valid[idx[5:0]]) begin
                rr_next_index = idx;
            end
        end
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin pick of the first valid index from a pointer
module rr_priority_picker
    import sync_fifo_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    valid,
    input  logic [ID_W-1:0] ptr,
    output logic            found,
    output logic [N-1:0]    onehot,
    output logic [ID_W-1:0] index
);

    int sel;

    always_comb begin
        sel    = rr_next_index(RR_MAX_N'(valid), int'(ptr), N);
        found  = (sel >= 0);
        index  = '0;
        onehot = '0;
        if (found) begin
            index         = ID_W'(sel);
            onehot[index] = 1'b1;
        end
    end

endmodule

// File: rtl/sync_fifo_wr_arbiter.sv
// rtl/sync_fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port among N_REQ producers
module sync_fifo_wr_arbiter
    import sync_fifo_arb_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int N_REQ      = 4,
    parameter  int MAX_BURST  = 4,
    localparam int ID_W       = $clog2(N_REQ),
    localparam int CNT_W      = $clog2(MAX_BURST + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic [N_REQ-1:0]            req_valid_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [N_REQ-1:0]            req_ready_o,
    input  logic                        fifo_full_i,
    output logic                        fifo_write_o,
    output logic [DATA_WIDTH-1:0]       fifo_wr_data_o,
    output logic [N_REQ-1:0]            grant_o,
    output logic [ID_W-1:0]             grant_id_o,
    output logic [CNT_W-1:0]            burst_cnt_o
);

    arb_state_t       state;
    logic [ID_W-1:0]  rr_ptr;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic [CNT_W-1:0] burst_cnt;

    logic             pick_found;
    logic [N_REQ-1:0] pick_onehot;
    logic [ID_W-1:0]  pick_index;

    logic cur_valid;
    logic xfer;
    logic last_beat;

    rr_priority_picker #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_picker (
        .valid  (req_valid_i),
        .ptr    (rr_ptr),
        .found  (pick_found),
        .onehot (pick_onehot),
        .index  (pick_index)
    );

    assign cur_valid = (state == BURST) && req_valid_i[grant_id];
    assign xfer      = cur_valid && !fifo_full_i;
    assign last_beat = (burst_cnt == CNT_W'(MAX_BURST - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant     <= '0;
            grant_id  <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state     <= BURST;
                        grant     <= pick_onehot;
                        grant_id  <= pick_index;
                        burst_cnt <= '0;
                    end
                end
                BURST: begin
                    // A full FIFO only stalls; the grant ends on a dropped valid or the final beat.
                    if (!cur_valid || (xfer && last_beat)) begin
                        state     <= IDLE;
                        grant     <= '0;
                        grant_id  <= '0;
                        burst_cnt <= '0;
                        rr_ptr    <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
                    end else if (xfer) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign req_ready_o  = (state == BURST && !fifo_full_i) ? grant : '0;
    assign fifo_write_o = xfer;
    assign grant_o      = grant;
    assign grant_id_o   = grant_id;
    assign burst_cnt_o  = burst_cnt;

    // One-hot grant select keeps the data bus at zero whenever nothing is granted.
    always_comb begin
        fifo_wr_data_o = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant[k]) begin
                fifo_wr_data_o = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// tb/tb_sync_fifo_wr_arbiter.sv - scoreboard bench for the round-robin FIFO write arbiter
module tb_sync_fifo_wr_arbiter;

    localparam int DW  = 32;
    localparam int NR  = 4;
    localparam int IDW = 2;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            cyc;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, full, use1;
    logic [NR-1:0]    v4, v1, rdy4, rdy1, g4, g1;
    logic [NR*DW-1:0] d4, d1;
    logic             wr4, wr1;
    logic [DW-1:0]    wd4, wd1;
    logic [IDW-1:0]   gid4, gid1;
    logic [2:0]       bc4;
    logic [0:0]       bc1;

    sync_fifo_wr_arbiter #(.DATA_WIDTH(DW), .N_REQ(NR), .MAX_BURST(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(v4), .req_data_i(d4), .req_ready_o(rdy4),
        .fifo_full_i(full), .fifo_write_o(wr4), .fifo_wr_data_o(wd4), .grant_o(g4),
        .grant_id_o(gid4), .burst_cnt_o(bc4)
    );

    sync_fifo_wr_arbiter #(.DATA_WIDTH(DW), .N_REQ(NR), .MAX_BURST(1)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(v1), .req_data_i(d1), .req_ready_o(rdy1),
        .fifo_full_i(full), .fifo_write_o(wr1), .fifo_wr_data_o(wd1), .grant_o(g1),
        .grant_id_o(gid1), .burst_cnt_o(bc1)
    );

    logic [NR-1:0]  rdy, g;
    logic           wr;
    logic [DW-1:0]  wd;
    logic [IDW-1:0] gid;
    assign rdy = use1 ? rdy1 : rdy4;
    assign g   = use1 ? g1   : g4;
    assign wr  = use1 ? wr1  : wr4;
    assign wd  = use1 ? wd1  : wd4;
    assign gid = use1 ? gid1 : gid4;

    logic [DW-1:0] src_q[NR][$];
    logic [DW-1:0] exp_r[NR][$];
    wr_t           exp_q[$];
    wr_t           obs_q[$];
    int            gnt_q[$];
    logic [NR-1:0] gv_q[$];
    logic [NR-1:0] en, vv, vv_prev, prev_g;
    int            cyc, total, bad;

    task automatic drive();
        logic [NR*DW-1:0] dd;
        dd = '0;
        for (int k = 0; k < NR; k++) begin
            vv[k] = en[k] && (src_q[k].size() > 0);
            if (vv[k]) dd[k*DW +: DW] = src_q[k][0];
        end
        v4 = use1 ? '0 : vv;
        v1 = use1 ? vv : '0;
        d4 = use1 ? '0 : dd;
        d1 = use1 ? dd : '0;
    endtask

    // One clock of producer behaviour; records grants and writes, compares nothing.
    task automatic cycle();
        logic [NR-1:0] acc;
        drive();
        @(negedge clk);
        if (g != '0 && prev_g == '0) begin
            gnt_q.push_back(int'(gid));
            gv_q.push_back(vv_prev);
        end
        prev_g  = g;
        vv_prev = vv;
        acc     = vv & rdy;
        if (wr) obs_q.push_back('{int'(gid), wd, cyc});
        @(posedge clk);
        #1;
        for (int k = 0; k < NR; k++) begin
            if (acc[k]) void'(src_q[k].pop_front());
        end
        cyc++;
    endtask

    task automatic clear_all();
        for (int k = 0; k < NR; k++) begin
            src_q[k].delete();
            exp_r[k].delete();
        end
        exp_q.delete();
        obs_q.delete();
        gnt_q.delete();
        gv_q.delete();
        en      = '1;
        vv      = '0;
        vv_prev = '0;
        prev_g  = '0;
        full    = 1'b0;
    endtask

    task automatic do_reset();
        clear_all();
        drive();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        full  = 1'b0;
        v4    = '1;
        d4    = {NR{32'hDEAD_BEEF}};
        #3;
        total++;
        if (g4 !== '0 || gid4 !== '0 || bc4 !== '0) begin
            bad++; $display("FAIL reset_grant: grant=%b id=%0d cnt=%0d, expected 0 0 0", g4, gid4, bc4);
        end
        total++;
        if (wr4 !== 1'b0 || rdy4 !== '0) begin
            bad++; $display("FAIL reset_write: write=%b ready=%b, expected 0 0000", wr4, rdy4);
        end
        total++;
        if (wd4 !== '0) begin
            bad++; $display("FAIL reset_data: data=%h, expected 0", wd4);
        end
        @(posedge clk);
        #1;
        total++;
        if (g4 !== '0) begin
            bad++; $display("FAIL reset_hold: grant=%b while in reset, expected 0000", g4);
        end
        v4    = '0;
        d4    = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int  base, n;
        int  ecyc[6] = '{1, 2, 3, 4, 6, 7};
        wr_t e, o;
        do_reset();
        base = cyc;
        for (int i = 0; i < 6; i++) begin
            src_q[2].push_back(DW'(32'hA0 + i));
            exp_q.push_back('{2, DW'(32'hA0 + i), base + ecyc[i]});
        end
        cycle();
        total++;
        if (g4 !== 4'b0100 || gid4 !== 2'd2) begin
            bad++; $display("FAIL single_latency: grant=%b id=%0d, expected 0100 2", g4, gid4);
        end
        n = 0;
        while ((src_q[2].size() > 0 || g4 !== '0) && n < 20) begin
            cycle();
            n++;
        end
        total++;
        if (n >= 20) begin
            bad++; $display("FAIL single_timeout: %0d words left, expected 0", src_q[2].size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL single_write: none, expected data=%h", e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.id != e.id || o.data !== e.data || o.cyc != e.cyc) begin
                    bad++; $display("FAIL single_write: id=%0d data=%h cyc=%0d, expected id=%0d data=%h cyc=%0d",
                                    o.id, o.data, o.cyc - base, e.id, e.data, e.cyc - base);
                end
            end
        end
        total++;
        if (obs_q.size() != 0 || gnt_q.size() != 2 || gnt_q[0] != 2 || gnt_q[1] != 2) begin
            bad++; $display("FAIL single_grants: extra_writes=%0d grants=%0d, expected 0 and two grants to 2",
                            obs_q.size(), gnt_q.size());
        end
    endtask

    task automatic test_round_robin();
        int  base, k, w;
        int  eg[5] = '{0, 1, 2, 3, 0};
        wr_t e, o;
        do_reset();
        base = cyc;
        for (int r = 0; r < NR; r++) begin
            for (int i = 0; i < 8; i++) src_q[r].push_back(32'hB000_0000 | DW'(r << 8) | DW'(i));
        end
        for (int n = 0; n < 5; n++) begin
            k = n % NR;
            for (int j = 0; j < 4; j++) begin
                w = (n / NR) * 4 + j;
                exp_q.push_back('{k, 32'hB000_0000 | DW'(k << 8) | DW'(w), base + 5 * n + 1 + j});
            end
        end
        for (int i = 0; i < 25; i++) cycle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL rr_write: none, expected id=%0d data=%h", e.id, e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.id != e.id || o.data !== e.data || o.cyc != e.cyc) begin
                    bad++; $display("FAIL rr_write: id=%0d data=%h cyc=%0d, expected id=%0d data=%h cyc=%0d",
                                    o.id, o.data, o.cyc - base, e.id, e.data, e.cyc - base);
                end
            end
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (gnt_q.size() <= i || gnt_q[i] != eg[i]) begin
                bad++; $display("FAIL rr_order: grant %0d is %0d, expected %0d", i,
                                (gnt_q.size() > i) ? gnt_q[i] : -1, eg[i]);
            end
        end
    endtask

    task automatic test_full_stall();
        int  base;
        int  ecyc[4] = '{1, 2, 6, 7};
        wr_t e, o;
        do_reset();
        base = cyc;
        for (int i = 0; i < 4; i++) begin
            src_q[1].push_back(DW'(32'hC1_0000 + i));
            exp_q.push_back('{1, DW'(32'hC1_0000 + i), base + ecyc[i]});
        end
        for (int i = 0; i < 3; i++) cycle();
        for (int i = 0; i < 3; i++) begin
            full = 1'b1;
            drive();
            #1;
            total++;
            if (wr4 !== 1'b0 || rdy4[1] !== 1'b0 || bc4 !== 3'd2 || g4 !== 4'b0010) begin
                bad++; $display("FAIL full_stall: write=%b ready1=%b cnt=%0d grant=%b, expected 0 0 2 0010",
                                wr4, rdy4[1], bc4, g4);
            end
            cycle();
        end
        full = 1'b0;
        cycle();
        cycle();
        total++;
        if (g4 !== '0 || src_q[1].size() != 0) begin
            bad++; $display("FAIL full_release: grant=%b left=%0d, expected 0000 0", g4, src_q[1].size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL full_write: none, expected data=%h", e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.id != e.id || o.data !== e.data || o.cyc != e.cyc) begin
                    bad++; $display("FAIL full_write: id=%0d data=%h cyc=%0d, expected id=%0d data=%h cyc=%0d",
                                    o.id, o.data, o.cyc - base, e.id, e.data, e.cyc - base);
                end
            end
        end
    endtask

    task automatic test_valid_drop();
        int  base;
        int  eg[4] = '{2, 3, 0, 3};
        wr_t e, o;
        do_reset();
        base = cyc;
        src_q[2].push_back(32'hF0);
        exp_q.push_back('{2, 32'hF0, base + 1});
        exp_q.push_back('{3, 32'hC0, base + 4});
        exp_q.push_back('{0, 32'hD0, base + 7});
        exp_q.push_back('{0, 32'hD1, base + 8});
        exp_q.push_back('{3, 32'hC1, base + 11});
        exp_q.push_back('{3, 32'hC2, base + 12});
        for (int i = 0; i < 14; i++) begin
            if (i == 3) begin
                for (int j = 0; j < 3; j++) src_q[3].push_back(DW'(32'hC0 + j));
                for (int j = 0; j < 2; j++) src_q[0].push_back(DW'(32'hD0 + j));
            end
            if (i == 5) en[3] = 1'b0;
            if (i == 6) en[3] = 1'b1;
            cycle();
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL drop_write: none, expected id=%0d data=%h", e.id, e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.id != e.id || o.data !== e.data || o.cyc != e.cyc) begin
                    bad++; $display("FAIL drop_write: id=%0d data=%h cyc=%0d, expected id=%0d data=%h cyc=%0d",
                                    o.id, o.data, o.cyc - base, e.id, e.data, e.cyc - base);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (gnt_q.size() <= i || gnt_q[i] != eg[i]) begin
                bad++; $display("FAIL drop_order: grant %0d is %0d, expected %0d", i,
                                (gnt_q.size() > i) ? gnt_q[i] : -1, eg[i]);
            end
        end
        total++;
        if (g4 !== '0) begin
            bad++; $display("FAIL drop_idle: grant=%b, expected 0000", g4);
        end
    endtask

    task automatic test_async_reset();
        int  base;
        wr_t e, o;
        do_reset();
        base = cyc;
        for (int i = 0; i < 6; i++) src_q[2].push_back(DW'(32'hE0 + i));
        exp_q.push_back('{2, 32'hE0, base + 1});
        exp_q.push_back('{2, 32'hE1, base + 2});
        for (int i = 0; i < 3; i++) begin
            if (i == 1) src_q[0].push_back(32'h50);
            cycle();
        end
        drive();
        total++;
        if (bc4 !== 3'd2 || g4 !== 4'b0100) begin
            bad++; $display("FAIL areset_pre: cnt=%0d grant=%b, expected 2 0100", bc4, g4);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (g4 !== '0 || gid4 !== '0 || bc4 !== '0) begin
            bad++; $display("FAIL areset_grant: grant=%b id=%0d cnt=%0d, expected 0 0 0", g4, gid4, bc4);
        end
        total++;
        if (wr4 !== 1'b0 || rdy4 !== '0 || wd4 !== '0) begin
            bad++; $display("FAIL areset_write: write=%b ready=%b data=%h, expected 0 0000 0", wr4, rdy4, wd4);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL areset_write_pre: none, expected data=%h", e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.id != e.id || o.data !== e.data || o.cyc != e.cyc) begin
                    bad++; $display("FAIL areset_write_pre: id=%0d data=%h cyc=%0d, expected id=%0d data=%h cyc=%0d",
                                    o.id, o.data, o.cyc - base, e.id, e.data, e.cyc - base);
                end
            end
        end
        prev_g  = '0;
        vv_prev = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();
        total++;
        if (g4 !== 4'b0001 || gid4 !== 2'd0) begin
            bad++; $display("FAIL areset_regrant: grant=%b id=%0d, expected 0001 0", g4, gid4);
        end
    endtask

    task automatic test_scoreboard();
        int            seq, gi;
        int            wt[NR];
        logic [NR-1:0] gvv;
        wr_t           o;
        use1 = 1'b1;
        do_reset();
        seq = 0;
        for (int k = 0; k < NR; k++) wt[k] = 0;
        for (int i = 0; i < 400; i++) begin
            if (i < 300) begin
                for (int k = 0; k < NR; k++) begin
                    if (src_q[k].size() == 0 && $urandom_range(1) == 1) begin
                        src_q[k].push_back(DW'(k << 24) | DW'(seq));
                        exp_r[k].push_back(DW'(k << 24) | DW'(seq));
                        seq++;
                    end
                end
            end
            full = (i < 300) && ($urandom_range(7) == 0);
            cycle();
            while (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                total++;
                if (exp_r[o.id].size() == 0) begin
                    bad++; $display("FAIL sb_data: req %0d wrote %h, expected no word", o.id, o.data);
                end else begin
                    if (o.data !== exp_r[o.id][0]) begin
                        bad++; $display("FAIL sb_data: req %0d wrote %h, expected %h", o.id, o.data, exp_r[o.id][0]);
                    end
                    void'(exp_r[o.id].pop_front());
                end
            end
            while (gnt_q.size() > 0) begin
                gi  = gnt_q.pop_front();
                gvv = gv_q.pop_front();
                total++;
                if (wt[gi] > NR - 1) begin
                    bad++; $display("FAIL sb_fair: req %0d waited %0d grants, expected at most %0d", gi, wt[gi], NR - 1);
                end
                wt[gi] = 0;
                for (int k = 0; k < NR; k++) begin
                    if (k != gi && gvv[k]) wt[k]++;
                end
            end
        end
        for (int k = 0; k < NR; k++) begin
            total++;
            if (exp_r[k].size() != 0 || src_q[k].size() != 0) begin
                bad++; $display("FAIL sb_drain: req %0d has %0d unwritten words, expected 0", k, exp_r[k].size());
            end
        end
        total++;
        if (g1 !== '0 || bc1 !== '0) begin
            bad++; $display("FAIL sb_idle: grant=%b cnt=%0d, expected 0000 0", g1, bc1);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        use1  = 1'b0;
        rst_n = 1'b0;
        clear_all();
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_valid_drop();
        test_async_reset();
        test_scoreboard();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
